// File: rtl/vga_timing_generator.sv
// VGA raster timing: detects rising edges of the divided pixel-rate level and steps h/v counters,
// decoding sync, active-video and coordinates one clk after each count; enable low freezes everything.
module vga_timing_generator #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          clk_div_i,
  input  logic          enable_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          video_on_o,
  output logic [HW-1:0] pixel_x_o,
  output logic [VW-1:0] pixel_y_o,
  output logic          pixel_tick_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

  logic          clk_div_q;
  logic [HW-1:0] h_count_q, h_count_d;
  logic [VW-1:0] v_count_q, v_count_d;
  logic          step;
  logic          step_q;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic [HW-1:0] pixel_x_q, pixel_x_d;
  logic [VW-1:0] pixel_y_q, pixel_y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // The divided signal is only ever sampled as data; its rising edge becomes a one-clk strobe.
  assign pixel_tick_o = clk_div_i & ~clk_div_q;
  assign step         = pixel_tick_o & enable_i;

  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (step) begin
      if (h_count_q == HW'(H_TOTAL - 1)) begin
        h_count_d = '0;
        if (v_count_q == VW'(V_TOTAL - 1)) begin
          v_count_d = '0;
        end else begin
          v_count_d = v_count_q + VW'(1);
        end
      end else begin
        h_count_d = h_count_q + HW'(1);
      end
    end
  end

  // Decode from the settled counters; pulses key off the step taken on the previous clk.
  always_comb begin
    video_on_d    = (h_count_q < HW'(H_ACTIVE)) && (v_count_q < VW'(V_ACTIVE));
    hsync_d       = ((h_count_q >= HW'(HS_FIRST)) && (h_count_q <= HW'(HS_LAST))) ?
                    HSYNC_POL : ~HSYNC_POL;
    vsync_d       = ((v_count_q >= VW'(VS_FIRST)) && (v_count_q <= VW'(VS_LAST))) ?
                    VSYNC_POL : ~VSYNC_POL;
    pixel_x_d     = video_on_d ? h_count_q : '0;
    pixel_y_d     = video_on_d ? v_count_q : '0;
    line_start_d  = step_q && (h_count_q == '0);
    frame_start_d = step_q && (h_count_q == '0) && (v_count_q == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      clk_div_q <= 1'b0;
      h_count_q <= '0;
      v_count_q <= '0;
      step_q    <= 1'b0;
    end else begin
      clk_div_q <= clk_div_i;
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      step_q    <= step;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (enable_i) begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign video_on_o    = video_on_q;
  assign pixel_x_o     = pixel_x_q;
  assign pixel_y_o     = pixel_y_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator on an 8x6 raster, model tracks a linear pixel index.
module tb_vga_timing_generator;

  localparam int HT   = 8;
  localparam int VT   = 6;
  localparam int NPOS = HT * VT;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_div;
  logic       enable;
  logic       hsync, vsync, video_on, pixel_tick, line_start, frame_start;
  logic [2:0] pixel_x;
  logic [2:0] pixel_y;

  vga_timing_generator #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .clk_div_i    (clk_div),
    .enable_i     (enable),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .video_on_o   (video_on),
    .pixel_x_o    (pixel_x),
    .pixel_y_o    (pixel_y),
    .pixel_tick_o (pixel_tick),
    .line_start_o (line_start),
    .frame_start_o(frame_start)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          pos = 0;
  bit          m_prev = 1'b0;
  bit          m_stepped = 1'b0;
  bit          chk = 1'b0;
  bit          acc = 1'b0;
  logic [10:0] exp_out = '0;
  int          ph = 0;
  int          a_tick, a_ls, a_fs, a_fsnols, a_vo, a_vslow;
  logic [2:0]  fs_px, fs_py;

  typedef struct {
    logic [2:0] px;
    logic       vo;
    logic       hs;
    logic       ls;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected registered outputs for raster position p: {hsync, vsync, video_on, x, y}.
  function automatic logic [8:0] decode(input int p);
    int   h, v;
    logic vo, hs, vs;
    logic [2:0] px, py;
    h  = p % HT;
    v  = p / HT;
    vo = (h < 4) && (v < 3);
    hs = !(h == 5 || h == 6);
    vs = (v != 4);
    px = vo ? 3'(h) : 3'd0;
    py = vo ? 3'(v) : 3'd0;
    return {hs, vs, vo, px, py};
  endfunction

  task automatic clear_acc();
    a_tick = 0; a_ls = 0; a_fs = 0; a_fsnols = 0; a_vo = 0; a_vslow = 0;
    fs_px = 3'd7; fs_py = 3'd7;
  endtask

  // One clk: drive at negedge, check tick, advance model at posedge, check outputs at next negedge.
  task automatic cyc(input logic r, input logic d, input logic e);
    logic tick, ls, fs;
    reset_n = r;
    clk_div = d;
    enable  = e;
    #1;
    if (chk) check("pixel_tick", pixel_tick, d & ~m_prev);
    if (acc && pixel_tick) a_tick++;
    @(posedge clk);
    tick = d & ~m_prev;
    if (!r) begin
      m_prev    = 1'b0;
      pos       = 0;
      m_stepped = 1'b0;
      exp_out   = {1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
    end else begin
      m_prev = d;
      if (e) begin
        ls      = m_stepped && (pos % HT == 0);
        fs      = m_stepped && (pos == 0);
        exp_out = {decode(pos), ls, fs};
      end else begin
        exp_out[1:0] = 2'b00;
      end
      m_stepped = tick && e;
      if (tick && e) pos = (pos + 1) % NPOS;
    end
    chk = 1'b1;
    @(negedge clk);
    check("outputs", {hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start}, exp_out);
    if (acc) begin
      if (line_start) a_ls++;
      if (frame_start) begin
        a_fs++;
        fs_px = pixel_x;
        fs_py = pixel_y;
        if (!line_start) a_fsnols++;
      end
      if (video_on) a_vo++;
      if (!vsync) a_vslow++;
    end
  endtask

  task automatic tick_clk(input logic e);
    cyc(1'b1, (ph >= 2), e);
    ph = (ph + 1) % 4;
  endtask

  initial begin
    logic rd, dd, ed;
    tbl[0] = '{3'd1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{3'd2, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{3'd3, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{3'd0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{3'd0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{3'd0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{3'd0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{3'd0, 1'b1, 1'b1, 1'b1};
    reset_n = 1'b0; clk_div = 1'b0; enable = 1'b0;
    clear_acc();
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("reset_hsync", hsync, 1'b1);
    check("reset_vsync", vsync, 1'b1);
    check("reset_video_on", video_on, 1'b0);
    ph = 0;

    // One tick per 4 clk.
    clear_acc(); acc = 1'b1;
    repeat (32) tick_clk(1'b1);
    acc = 1'b0;
    check("t1_tick_count", a_tick, 8);
    check("t1_px", pixel_x, 0);
    check("t1_py", pixel_y, 1);
    check("t1_line_start", line_start, 1);

    // Full line, sampled after each tick's registered update.
    for (int i = 0; i < 8; i++) begin
      repeat (4) tick_clk(1'b1);
      check("t2_pixel_x", pixel_x, tbl[i].px);
      check("t2_video_on", video_on, tbl[i].vo);
      check("t2_hsync", hsync, tbl[i].hs);
      check("t2_line_start", line_start, tbl[i].ls);
    end

    // Output lags the counter update by one clk.
    repeat (4) tick_clk(1'b1);
    repeat (3) tick_clk(1'b1);
    check("t1_lag_px", pixel_x, 1);
    tick_clk(1'b1);
    check("t1_new_px", pixel_x, 2);

    // Full frame starting from (2, 2).
    clear_acc(); acc = 1'b1;
    repeat (48 * 4) tick_clk(1'b1);
    acc = 1'b0;
    check("t3_line_starts", a_ls, 6);
    check("t3_frame_starts", a_fs, 1);
    check("t3_fs_without_ls", a_fsnols, 0);
    check("t3_fs_px", fs_px, 0);
    check("t3_fs_py", fs_py, 0);
    check("t3_video_on_cycles", a_vo, 48);
    check("t3_vsync_low_cycles", a_vslow, 32);
    check("t3_end_px", pixel_x, 2);
    check("t3_end_py", pixel_y, 2);

    // Freeze at h = 2 for 12 clk.
    clear_acc(); acc = 1'b1;
    repeat (12) tick_clk(1'b0);
    acc = 1'b0;
    check("t4_pulses", a_ls + a_fs, 0);
    check("t4_px_held", pixel_x, 2);
    check("t4_py_held", pixel_y, 2);
    check("t4_video_on_held", video_on, 1);
    repeat (4) tick_clk(1'b1);
    check("t4_resume_px", pixel_x, 3);

    // Reset at (6, 4) coincident with a tick.
    repeat (19 * 4) tick_clk(1'b1);
    check("t5_pre_hsync", hsync, 0);
    check("t5_pre_vsync", vsync, 0);
    tick_clk(1'b1);
    tick_clk(1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    ph = 3;
    check("t5_hsync", hsync, 1);
    check("t5_vsync", vsync, 1);
    check("t5_video_on", video_on, 0);
    check("t5_px", pixel_x, 0);
    check("t5_py", pixel_y, 0);
    tick_clk(1'b1);
    check("t5_origin_video_on", video_on, 1);
    check("t5_origin_px", pixel_x, 0);
    check("t5_origin_py", pixel_y, 0);

    // clk_div stuck high then low: a single tick.
    clear_acc(); acc = 1'b1;
    repeat (2) cyc(1'b1, 1'b0, 1'b1);
    repeat (20) cyc(1'b1, 1'b1, 1'b1);
    repeat (10) cyc(1'b1, 1'b0, 1'b1);
    acc = 1'b0;
    check("t6_tick_count", a_tick, 1);
    check("t6_px", pixel_x, 2);
    ph = 0;

    // Random traffic against the model.
    dd = clk_div;
    for (int i = 0; i < 800; i++) begin
      rd = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 2) == 0) dd = ~dd;
      ed = ($urandom_range(0, 7) != 0);
      cyc(rd, dd, ed);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
Consumes the divided pixel-rate signal from the clock divider stage. Generates horizontal/vertical sync, the active-video flag and pixel coordinates for the VGA output path. Everything runs in the single system clock domain. The divided signal is never used as a clock: its rising edges are detected and turned into a one-cycle pixel tick.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync

Derived widths:
- H_TOTAL = sum of H_*; V_TOTAL = sum of V_*.
- HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL).

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
clk_div  in  1  divided pixel-rate level from the clock divider (toggling signal)
enable  in  1  1 = timing runs; 0 = freeze
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
video_on  out  1  high while inside the active area
pixel_x  out  HW  column; 0 outside the active area
pixel_y  out  VW  row; 0 outside the active area
pixel_tick  out  1  one-clk pulse per pixel (rising edge of clk_div)
line_start  out  1  one-clk pulse when h_count wraps to 0
frame_start  out  1  one-clk pulse when (h_count, v_count) wraps to (0, 0)

Behaviour:
- Reset is synchronous, active-low: one clk edge with reset_n = 0 applies it. Reset values:
  - clk_div_d = 0; h_count = 0; v_count = 0.
  - hsync = ~HSYNC_POL; vsync = ~VSYNC_POL.
  - video_on, pixel_x, pixel_y, line_start, frame_start = 0.
- Reset mid-frame: the same values apply at the next edge; counting restarts from (0, 0).
- Edge detect:
  - clk_div_d registers clk_div every clk, including while enable = 0.
  - pixel_tick = clk_div & ~clk_div_d, combinational. It lasts exactly one clk per clk_div rising edge.
- Counter step: on a clk edge with pixel_tick = 1 and enable = 1:
  - h_count increments; at H_TOTAL-1 it wraps to 0.
  - v_count increments only on an h wrap; at V_TOTAL-1 it wraps to 0.
  - Otherwise both counters hold.
- Ticks with enable = 0 are discarded, not queued. Reasserting enable resumes from the held counts.
- Outputs are registered from the current counter values. They lag the counter update by exactly 1 clk.
- Output decode (boundaries inclusive):
  - video_on = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
  - hsync = HSYNC_POL when H_ACTIVE+H_FP <= h_count <= H_ACTIVE+H_FP+H_SYNC-1, else ~HSYNC_POL.
  - vsync = VSYNC_POL when V_ACTIVE+V_FP <= v_count <= V_ACTIVE+V_FP+V_SYNC-1, else ~VSYNC_POL. It is level-based on v_count and changes only at line boundaries.
  - pixel_x = video_on ? h_count : 0; pixel_y = video_on ? v_count : 0.
- Pulses:
  - line_start: high for 1 clk, on the clk after the counter step that wrapped h_count to 0.
  - frame_start: same timing, on the step where both counters wrap. line_start is also high on that cycle.
- While enable = 0, all registered outputs hold. line_start and frame_start are 0.
- Simultaneous reset_n = 0 and pixel_tick = 1: reset wins.

Test Plan:
Small parameters for all scenarios: H = 4/1/2/1 (H_TOTAL 8), V = 3/1/1/1 (V_TOTAL 6), polarities 0. Bench drives clk_div with period 4 clk.

1. Reset, then enable = 1 -> exactly one pixel_tick per 4 clk. Each tick advances h_count by 1. Outputs lag the counter by exactly 1 clk.
2. One full line -> video_on high for h = 0..3; hsync low for h = 5..6; line_start pulses once per 8 ticks; pixel_x sequence 0,1,2,3,0,0,0,0.
3. One full frame (48 ticks) -> vsync low only during line 4; video_on never high on lines 3..5; frame_start pulses once, coincident with a line_start; counters return to (0, 0).
4. enable = 0 for 12 clk mid-line at h = 2 -> counters and outputs frozen; no line_start/frame_start. After re-enable, the next tick gives h = 3.
5. reset_n = 0 for 1 clk at (h = 6, v = 4), aligned with a pixel_tick -> next cycle: counters (0, 0), hsync = 1, vsync = 1, video_on = 0. The tick is not counted.
6. clk_div held high for 20 clk, then held low -> no pixel_tick after the initial rising edge; counters hold.
